// File: rtl/audio_meter_ctrl_if.sv
// Sample stream from the audio capture block into the volume meter.
interface audio_meter_ctrl_if;
  logic [11:0] sample;
  logic        sample_valid;

  modport master (output sample, output sample_valid);
  modport slave  (input sample, input sample_valid);
endinterface

// File: rtl/audio_meter_ctrl.sv
// Microphone volume meter: windowed peak -> 0..15 level, LED bar and 4-digit scan.
// Optional peak-hold decay of the displayed level when AUDIO_METER_HOLD_EN is defined.
module audio_meter_ctrl #(
  parameter int WINDOW_SAMPLES = 10000,
  parameter int REFRESH_DIV    = 100000,
  parameter int NOISE_FLOOR    = 2175
) (
  input  logic              CLK,
  input  logic              reset,
  audio_meter_ctrl_if.slave audio,
  output logic [3:0]        level,
  output logic              level_valid,
  output logic [15:0]       LED,
  output logic [6:0]        SEG,
  output logic [3:0]        AN,
  output logic              DP
);

  localparam int WW = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WINDOW_SAMPLES - 1);
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
  localparam logic [11:0]   FLOOR = 12'(NOISE_FLOOR);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t        state;
  state_t        state_next;
  logic [WW-1:0] wcnt;
  logic [11:0]   peak;
  logic [11:0]   peak_new;
  logic          closing;
  logic [3:0]    win_level;
  logic [3:0]    level_next;
  logic [RW-1:0] rcnt;
  logic [1:0]    slot;
  logic [3:0]    units;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  function automatic logic [3:0] map_level(input logic [11:0] p);
    logic [11:0] d;
    d = (p - FLOOR - 12'd1) >> 7;
    if (p <= FLOOR)
      return 4'd0;
    else if (d >= 12'd15)
      return 4'd15;
    else
      return d[3:0] + 4'd1;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (audio.sample_valid) state_next = ACCUM;
      ACCUM:   state_next = ACCUM;
      default: state_next = IDLE;
    endcase
  end

  // The closing sample still counts toward the window it closes.
  always_comb begin
    peak_new  = (audio.sample > peak) ? audio.sample : peak;
    closing   = audio.sample_valid && (wcnt == WLAST);
    win_level = map_level(peak_new);
`ifdef AUDIO_METER_HOLD_EN
    level_next = (win_level >= level) ? win_level : level - 4'd1;
`else
    level_next = win_level;
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wcnt        <= '0;
      peak        <= '0;
      level       <= 4'd0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (audio.sample_valid) begin
        if (closing) begin
          wcnt        <= '0;
          peak        <= '0;
          level       <= level_next;
          level_valid <= 1'b1;
        end else begin
          wcnt <= wcnt + WW'(1);
          peak <= peak_new;
        end
      end
    end
  end

  always_comb begin
    LED = '0;
    for (int i = 0; i < 16; i++)
      LED[i] = (4'(i) <= level);
  end

  // Leading tens digit is blanked below 10; slots 2 and 3 are always dark.
  always_comb begin
    units    = (level >= 4'd10) ? level - 4'd10 : level;
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    case (slot)
      2'd0: begin
        an_next  = 4'b1110;
        seg_next = seg_code(units);
      end
      2'd1: begin
        if (level >= 4'd10) begin
          an_next  = 4'b1101;
          seg_next = seg_code(4'd1);
        end
      end
      default: begin
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rcnt <= '0;
      slot <= 2'd0;
      AN   <= 4'b1111;
      SEG  <= 7'b1111111;
    end else begin
      if (rcnt == RLAST) begin
        rcnt <= '0;
        slot <= slot + 2'd1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      AN  <= an_next;
      SEG <= seg_next;
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_audio_meter_ctrl.sv
// Self-checking bench for audio_meter_ctrl with a small window/refresh and a spec-level model.
module tb_audio_meter_ctrl;

  localparam int W  = 4;
  localparam int R  = 4;
  localparam int NF = 2175;

  logic        CLK;
  logic        reset;
  logic [3:0]  level;
  logic        level_valid;
  logic [15:0] LED;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;

  audio_meter_ctrl_if aif ();

  audio_meter_ctrl #(
    .WINDOW_SAMPLES (W),
    .REFRESH_DIV    (R),
    .NOISE_FLOOR    (NF)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .audio       (aif.slave),
    .level       (level),
    .level_valid (level_valid),
    .LED         (LED),
    .SEG         (SEG),
    .AN          (AN),
    .DP          (DP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int m_cnt   = 0;
  int m_peak  = 0;
  int m_level = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  always @(posedge CLK) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int spec_level(input int p);
    int l;
    if (p <= NF) return 0;
    l = (p - NF - 1) / 128 + 1;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic logic [15:0] spec_led(input int lvl);
    return 16'((32'd1 << (lvl + 1)) - 1);
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_peak  = 0;
    m_level = 0;
  endtask

  // One accepted sample; checks the window report when this sample closes a window.
  task automatic apply_stimulus(input int s);
    int  wl;
    bit  close;
    aif.sample       = 12'(s);
    aif.sample_valid = 1'b1;
    @(posedge CLK);
    #1;
    aif.sample_valid = 1'b0;
    if (s > m_peak) m_peak = s;
    m_cnt++;
    close = (m_cnt == W);
    if (close) begin
      wl = spec_level(m_peak);
`ifdef AUDIO_METER_HOLD_EN
      m_level = (wl >= m_level) ? wl : m_level - 1;
`else
      m_level = wl;
`endif
      m_cnt  = 0;
      m_peak = 0;
      check_output("level", 32'(level), 32'(m_level));
      check_output("led", 32'(LED), 32'(spec_led(m_level)));
    end
    check_output("level_valid", 32'(level_valid), 32'(close));
  endtask

  task automatic idle_cycle();
    @(posedge CLK);
    #1;
    check_output("idle_level_valid", 32'(level_valid), 32'd0);
    check_output("idle_level", 32'(level), 32'(m_level));
  endtask

  task automatic apply_window(input int s0, input int s1, input int s2, input int s3);
    apply_stimulus(s0);
    apply_stimulus(s1);
    apply_stimulus(s2);
    apply_stimulus(s3);
  endtask

  task automatic check_display(input int n);
    int         s;
    logic [3:0] ean;
    logic [6:0] eseg;
    repeat (n) begin
      @(posedge CLK);
      #1;
      s    = ((cyc - 1) / R) % 4;
      ean  = 4'b1111;
      eseg = 7'b1111111;
      if (s == 0) begin
        ean  = 4'b1110;
        eseg = seg_tab[m_level % 10];
      end else if (s == 1 && m_level >= 10) begin
        ean  = 4'b1101;
        eseg = seg_tab[1];
      end
      check_output("an", 32'(AN), 32'(ean));
      if (ean != 4'b1111 || s >= 2)
        check_output("seg", 32'(SEG), 32'(eseg));
    end
  endtask

  initial begin
    int gap;
    reset            = 1'b1;
    aif.sample       = 12'd0;
    aif.sample_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b0;
    model_reset();

    check_output("rst_level", 32'(level), 32'd0);
    check_output("rst_level_valid", 32'(level_valid), 32'd0);
    check_output("rst_led", 32'(LED), 32'h0001);
    check_output("rst_an", 32'(AN), 32'hF);
    check_output("rst_seg", 32'(SEG), 32'h7F);
    check_output("rst_dp", 32'(DP), 32'd1);
    @(posedge CLK);
    #1;
    check_output("first_an", 32'(AN), 32'hE);
    check_output("first_seg", 32'(SEG), 32'(7'b1000000));

    apply_window(2000, 3000, 2500, 2300);
    check_output("win1_level", 32'(level), 32'd7);
    check_output("win1_led", 32'(LED), 32'h00FF);
    idle_cycle();

    apply_window(100, 2175, 2175, 0);
    idle_cycle();
    apply_window(2176, 2000, 1, 2176);
    idle_cycle();
    apply_window(4095, 0, 4095, 12);
    check_output("max_led", 32'(LED), 32'hFFFF);
    idle_cycle();

    for (int w = 0; w < 12; w++) begin
      for (int k = 0; k < W; k++) begin
        apply_stimulus($urandom_range(0, 4095));
        gap = $urandom_range(0, 2);
        repeat (gap) idle_cycle();
      end
    end

    apply_window(3584, 100, 200, 300);
    idle_cycle();
    check_display(20);
    apply_window(3200, 3000, 100, 0);
    idle_cycle();
    check_display(20);

    apply_stimulus(4000);
    apply_stimulus(4000);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    model_reset();
    check_output("midrst_level", 32'(level), 32'd0);
    check_output("midrst_level_valid", 32'(level_valid), 32'd0);
    apply_window(2000, 2000, 2000, 2000);
    check_output("midrst_win_level", 32'(level), 32'd0);
    idle_cycle();

    apply_window(4095, 4095, 4095, 4095);
    check_output("hold_a", 32'(level), 32'd15);
    apply_window(100, 100, 100, 100);
`ifdef AUDIO_METER_HOLD_EN
    check_output("hold_b", 32'(level), 32'd14);
`else
    check_output("hold_b", 32'(level), 32'd0);
`endif
    apply_window(100, 100, 100, 100);
`ifdef AUDIO_METER_HOLD_EN
    check_output("hold_c", 32'(level), 32'd13);
`else
    check_output("hold_c", 32'(level), 32'd0);
`endif
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
